// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: MMCM lock qualification plus NUM_CH glitch-free programmable
// divided clocks (square wave + one-cycle enable).
// Optional macro CLK_DIV_LOCK_FILTER_EN: when defined, locked must stay high
// for LOCK_STABLE cycles before lock_ok; when undefined, lock_ok follows the
// synchronised locked input directly.

// One divider channel: half-period counter, toggle output, deferred reload.
module clk_div_ch #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             lock_ok,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             out,
  output logic             ce,
  output logic             busy
);
  logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d, hp_m1;
  logic             out_q, out_d, ce_q, ce_d, busy_q, busy_d;
  logic             last, fall;

  // Next-state: counting, toggling, and reload only at period boundaries
  always_comb begin
    hp_m1  = (act_q == '0) ? '0 : act_q - 1'b1;
    last   = (cnt_q == hp_m1);
    cnt_d  = cnt_q;
    out_d  = out_q;
    ce_d   = 1'b0;
    act_d  = act_q;
    pend_d = pend_q;
    busy_d = busy_q;
    fall   = 1'b0;
    if (!lock_ok) begin
      // lock loss kills the output at once; pending reload survives
      cnt_d = '0;
      out_d = 1'b0;
    end else if (run || out_q) begin
      // a disabled channel still finishes its high half-period
      if (last) begin
        cnt_d = '0;
        out_d = !out_q;
        ce_d  = !out_q;
        fall  = out_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
    // a strobe always wins, so a load on a toggle edge waits a full period
    if (load) begin
      pend_d = load_val;
      busy_d = 1'b1;
    end else if (busy_q && (fall || (!run && !out_q))) begin
      act_d  = pend_q;
      busy_d = 1'b0;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      act_q  <= DIV_W'(1);
      pend_q <= DIV_W'(1);
      out_q  <= 1'b0;
      ce_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      out_q  <= out_d;
      ce_q   <= ce_d;
      busy_q <= busy_d;
    end
  end

  assign out  = out_q;
  assign ce   = ce_q;
  assign busy = busy_q;
endmodule

module clk_div_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_STABLE = 1024,
  parameter int LOCK_CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    locked_in,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       clk_div_out,
  output logic [NUM_CH-1:0]       clk_div_ce,
  output logic [NUM_CH-1:0]       div_busy,
  output logic                    lock_ok,
  output logic                    rst_out_n,
  output logic [7:0]              lock_lost_cnt
);
`ifdef CLK_DIV_LOCK_FILTER_EN
  typedef enum logic [1:0] {WAIT_LOCK, STABLE_CNT, RUN} state_t;
  localparam logic [LOCK_CNT_W-1:0] STAB_LAST = LOCK_CNT_W'(LOCK_STABLE - 1);
  logic [LOCK_CNT_W-1:0] stab_q, stab_d;
`else
  typedef enum logic [1:0] {WAIT_LOCK, RUN} state_t;
`endif

  state_t     state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic       locked_s, lock_ok_q, lock_ok_d, rst_out_q;
  logic [7:0] lost_q, lost_d;

  assign locked_s = sync_q[1];

  // Lock FSM next-state; lock_ok is decoded from the next state so it is registered
  always_comb begin
    sync_d  = {sync_q[0], locked_in};
    state_d = state_q;
    lost_d  = lost_q;
`ifdef CLK_DIV_LOCK_FILTER_EN
    stab_d  = stab_q;
`endif
    case (state_q)
      WAIT_LOCK: begin
`ifdef CLK_DIV_LOCK_FILTER_EN
        stab_d = '0;
        if (locked_s) state_d = STABLE_CNT;
`else
        if (locked_s) state_d = RUN;
`endif
      end
`ifdef CLK_DIV_LOCK_FILTER_EN
      STABLE_CNT: begin
        if (!locked_s)                state_d = WAIT_LOCK;
        else if (stab_q == STAB_LAST) state_d = RUN;
        else                          stab_d  = stab_q + 1'b1;
      end
`endif
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          if (lost_q != 8'hFF) lost_d = lost_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    lock_ok_d = (state_d == RUN);
  end

  // Synchroniser, lock FSM and its registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state_q   <= WAIT_LOCK;
      lock_ok_q <= 1'b0;
      rst_out_q <= 1'b0;
      lost_q    <= '0;
`ifdef CLK_DIV_LOCK_FILTER_EN
      stab_q    <= '0;
`endif
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      lock_ok_q <= lock_ok_d;
      rst_out_q <= lock_ok_d;
      lost_q    <= lost_d;
`ifdef CLK_DIV_LOCK_FILTER_EN
      stab_q    <= stab_d;
`endif
    end
  end

  assign lock_ok       = lock_ok_q;
  assign rst_out_n     = rst_out_q;
  assign lock_lost_cnt = lost_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(.DIV_W(DIV_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (ch_en[i] & lock_ok_q),
      .lock_ok  (lock_ok_q),
      .load     (div_load[i]),
      .load_val (div_val[i*DIV_W +: DIV_W]),
      .out      (clk_div_out[i]),
      .ce       (clk_div_ce[i]),
      .busy     (div_busy[i])
    );
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: the driver pushes expected event cycles
// (ce pulses, output falls, lock_ok edges); a monitor pops them as they occur.
`timescale 1ns/1ps
module tb_clk_div_ctrl;
  localparam int NUM_CH = 4, DIV_W = 8, LOCK_STABLE = 16, LOCK_CNT_W = 16;
`ifdef CLK_DIV_LOCK_FILTER_EN
  localparam int LK = LOCK_STABLE;
`else
  localparam int LK = 0;
`endif
  localparam int EV_CE = 0, EV_FALL = 1, EV_LRISE = 2, EV_LFALL = 3;

  logic                    clk = 1'b0, rst_n = 1'b0, locked_in = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_val = '0;
  logic [NUM_CH-1:0]       div_load = '0, ch_en = '0;
  logic [NUM_CH-1:0]       clk_div_out, clk_div_ce, div_busy;
  logic                    lock_ok, rst_out_n;
  logic [7:0]              lock_lost_cnt;

  int cyc = 0, checks = 0, errors = 0, exp_lost = 0;
  bit mon_en = 1'b0;

  typedef struct {int kind; int ch; int cyc;} ev_t;
  ev_t exp_q[$];

  clk_div_ctrl #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_STABLE(LOCK_STABLE),
                 .LOCK_CNT_W(LOCK_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .locked_in(locked_in), .div_val(div_val),
    .div_load(div_load), .ch_en(ch_en), .clk_div_out(clk_div_out),
    .clk_div_ce(clk_div_ce), .div_busy(div_busy), .lock_ok(lock_ok),
    .rst_out_n(rst_out_n), .lock_lost_cnt(lock_lost_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_CE:    return "ce";
      EV_FALL:  return "fall";
      EV_LRISE: return "lock_rise";
      default:  return "lock_fall";
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int ch, input int c);
    ev_t e;
    e.kind = k; e.ch = ch; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Expected ce/fall cycles for n periods, first run edge e, effective half-period hp
  task automatic push_run(input int ch, input int e, input int hp, input int n);
    for (int k = 0; k < n; k++) begin
      push(EV_CE, ch, e + hp - 1 + 2*hp*k);
      push(EV_FALL, ch, e + 2*hp - 1 + 2*hp*k);
    end
  endtask

  task automatic wait_until(input int c);
    if (cyc > c) begin
      checks++; errors++;
      $display("FAIL sched: at cycle %0d, target %0d", cyc, c);
    end
    while (cyc < c) tick();
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin tick(); n++; end
    repeat (6) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      foreach (exp_q[i])
        $display("FAIL missing %s ch%0d: got none expected cycle %0d",
                 kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].cyc);
      exp_q.delete();
    end
  endtask

  // Idle channel: load applies on the edge after capture
  task automatic load_idle(input int ch, input int val);
    div_val[ch*DIV_W +: DIV_W] = DIV_W'(val);
    div_load[ch] = 1'b1;
    tick();
    div_load[ch] = 1'b0;
    chk("busy_set", int'(div_busy[ch]), 1);
    tick();
    chk("busy_clr_idle", int'(div_busy[ch]), 0);
  endtask

  task automatic lock_up();
    locked_in = 1'b1;
    push(EV_LRISE, 0, cyc + 3 + LK);
  endtask

  task automatic lock_down();
    locked_in = 1'b0;
    push(EV_LFALL, 0, cyc + 3);
    if (exp_lost < 255) exp_lost++;
  endtask

  task automatic match(input int kind, input int ch);
    int idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i].kind == kind && exp_q[i].ch == ch) idx = i;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected %s ch%0d at cycle %0d", kname(kind), ch, cyc);
    end else begin
      if (exp_q[idx].cyc != cyc) begin
        errors++;
        $display("FAIL %s ch%0d: got cycle %0d expected cycle %0d",
                 kname(kind), ch, cyc, exp_q[idx].cyc);
      end
      exp_q.delete(idx);
    end
  endtask

  // Monitor: samples on the falling edge and retires expected events
  initial begin : mon
    logic [NUM_CH-1:0] prev_out;
    logic              prev_lock;
    prev_out  = '0;
    prev_lock = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (clk_div_ce[ch]) match(EV_CE, ch);
          if (prev_out[ch] && !clk_div_out[ch]) match(EV_FALL, ch);
          if (clk_div_ce[ch] || (clk_div_out[ch] && !prev_out[ch]))
            chk("ce_on_rise", int'(clk_div_ce[ch]), int'(clk_div_out[ch] && !prev_out[ch]));
        end
        if (lock_ok != prev_lock) begin
          match(lock_ok ? EV_LRISE : EV_LFALL, 0);
          chk("rst_out_eq_lock", int'(rst_out_n), int'(lock_ok));
        end
      end
      prev_out  = clk_div_out;
      prev_lock = lock_ok;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout: got no finish expected finish by 1ms");
    $fatal(1, "timeout");
  end

  initial begin : drv
    int c, e;
    repeat (3) tick();
    chk("rst_out",  int'(clk_div_out), 0);
    chk("rst_ce",   int'(clk_div_ce), 0);
    chk("rst_busy", int'(div_busy), 0);
    chk("rst_lock", int'(lock_ok), 0);
    chk("rst_rstn", int'(rst_out_n), 0);
    chk("rst_lost", int'(lock_lost_cnt), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("lock_idle", int'(lock_ok), 0);
    mon_en = 1'b1;

    // Lock qualification with a one-cycle glitch sampled on edge S+9
    c = cyc;
    locked_in = 1'b1;
`ifdef CLK_DIV_LOCK_FILTER_EN
    push(EV_LRISE, 0, c + 13 + LOCK_STABLE);
`else
    push(EV_LRISE, 0, c + 3);
    push(EV_LFALL, 0, c + 12);
    push(EV_LRISE, 0, c + 13);
    exp_lost = 1;
`endif
    wait_until(c + 9);
    locked_in = 1'b0;
    tick();
    locked_in = 1'b1;
    drain(60);
    chk("lost_after_glitch", int'(lock_lost_cnt), exp_lost);

    // ch0 hp=3: rise on 3rd run edge, period 6; stop while low
    load_idle(0, 3);
    ch_en[0] = 1'b1; e = cyc + 1;
    push_run(0, e, 3, 3);
    wait_until(e + 17);
    ch_en[0] = 1'b0;
    drain(40);

    // ch1 hp=0 behaves as hp=1: period 2
    load_idle(1, 0);
    ch_en[1] = 1'b1; e = cyc + 1;
    push_run(1, e, 1, 4);
    wait_until(e + 7);
    ch_en[1] = 1'b0;
    drain(40);

    // Reload sequence on ch0: 4 -> 2 (high phase), 5 then 3 (last wins),
    // 1 captured on a falling toggle edge (waits a full period)
    load_idle(0, 4);
    ch_en[0] = 1'b1; e = cyc + 1;
    push(EV_CE, 0, e + 3);  push(EV_FALL, 0, e + 7);
    push(EV_CE, 0, e + 9);  push(EV_FALL, 0, e + 11);
    push(EV_CE, 0, e + 13); push(EV_FALL, 0, e + 15);
    push(EV_CE, 0, e + 17); push(EV_FALL, 0, e + 19);
    push(EV_CE, 0, e + 22); push(EV_FALL, 0, e + 25);
    push(EV_CE, 0, e + 28); push(EV_FALL, 0, e + 31);
    push(EV_CE, 0, e + 32); push(EV_FALL, 0, e + 33);
    wait_until(e + 4);
    div_val[0 +: DIV_W] = 8'd2; div_load[0] = 1'b1;
    tick(); div_load[0] = 1'b0;
    chk("busy_hi_phase", int'(div_busy[0]), 1);
    wait_until(e + 6);  chk("busy_hold", int'(div_busy[0]), 1);
    wait_until(e + 7);  chk("busy_clr_fall", int'(div_busy[0]), 0);
    wait_until(e + 15);
    div_val[0 +: DIV_W] = 8'd5; div_load[0] = 1'b1;
    tick(); div_val[0 +: DIV_W] = 8'd3;
    tick(); div_load[0] = 1'b0;
    wait_until(e + 18); chk("busy_two_loads", int'(div_busy[0]), 1);
    wait_until(e + 19); chk("busy_clr_two", int'(div_busy[0]), 0);
    wait_until(e + 24);
    div_val[0 +: DIV_W] = 8'd1; div_load[0] = 1'b1;
    tick(); div_load[0] = 1'b0;
    chk("busy_on_toggle", int'(div_busy[0]), 1);
    wait_until(e + 30); chk("busy_wait_full", int'(div_busy[0]), 1);
    wait_until(e + 31); chk("busy_clr_late", int'(div_busy[0]), 0);
    wait_until(e + 33);
    ch_en[0] = 1'b0;
    drain(40);

    // Disable ch2 (hp=5) one cycle into high phase; ch3 (hp=2) keeps running
    load_idle(2, 5);
    load_idle(3, 2);
    ch_en[3:2] = 2'b11; e = cyc + 1;
    push(EV_CE, 2, e + 4); push(EV_FALL, 2, e + 9);
    push_run(3, e, 2, 6);
    wait_until(e + 4);
    ch_en[2] = 1'b0;
    wait_until(e + 23);
    ch_en[3] = 1'b0;
    drain(40);
    repeat (10) tick();
    chk("dis_out_low", int'(clk_div_out), 0);

    // Lock loss while ch0 is high
    load_idle(0, 6);
    ch_en[0] = 1'b1; e = cyc + 1;
    push(EV_CE, 0, e + 5);
    wait_until(e + 5);
    lock_down();
    push(EV_FALL, 0, e + 9);
    wait_until(e + 8);
    chk("loss_out_still_hi", int'(clk_div_out[0]), 1);
    chk("loss_rstn", int'(rst_out_n), 0);
    wait_until(e + 9);
    chk("loss_out", int'(clk_div_out[0]), 0);
    chk("loss_cnt", int'(lock_lost_cnt), exp_lost);
    ch_en[0] = 1'b0;
    drain(40);

    // Repeated lock loss saturates the counter
    for (int i = 0; i < 300; i++) begin
      lock_up();
      repeat (LK + 5) tick();
      lock_down();
      repeat (5) tick();
      if (i == 9) chk("lost_mid", int'(lock_lost_cnt), exp_lost);
    end
    drain(40);
    chk("lost_sat", int'(lock_lost_cnt), 255);

    // Asynchronous reset in the middle of activity
    lock_up();
    drain(60);
    mon_en = 1'b0;
    ch_en = '1;
    repeat (15) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out",  int'(clk_div_out), 0);
    chk("mid_rst_ce",   int'(clk_div_ce), 0);
    chk("mid_rst_busy", int'(div_busy), 0);
    chk("mid_rst_lock", int'(lock_ok), 0);
    chk("mid_rst_rstn", int'(rst_out_n), 0);
    chk("mid_rst_lost", int'(lock_lost_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Parametrised clock-qualification and divided-clock generator that sits after the MMCM in the system clock tree. It filters the MMCM `locked` status into a stable `lock_ok` and a sequenced fabric reset. It produces NUM_CH independently programmable divided clocks (square wave plus one-cycle clock enable) from a single BUFG'd source clock. Each channel's divider can be reprogrammed at run time without glitches, which replaces fixed two-way BUFGMUX rate selection for SPI/encoder/JTAG-class clocks.

## Interface
- NUM_CH, 4, number of divider channels (1-8)
- DIV_W, 8, width of each half-period divide value
- LOCK_STABLE, 1024, cycles locked must stay high before `lock_ok` (>=2)
- LOCK_CNT_W, 16, width of the stability counter (2^LOCK_CNT_W > LOCK_STABLE)

- clk  in  1  source clock (BUFG output); all logic on rising edge
- rst_n  in  1  asynchronous active-low reset, deasserted synchronously upstream
- locked_in  in  1  MMCM LOCKED, asynchronous to clk
- div_val  in  NUM_CH*DIV_W  half-period divide value per channel; ch i at [i*DIV_W +: DIV_W]
- div_load  in  NUM_CH  one-cycle strobe: capture div_val for channel i
- ch_en  in  NUM_CH  channel run enable
- clk_div_out  out  NUM_CH  registered divided clock
- clk_div_ce  out  NUM_CH  one-cycle pulse coincident with clk_div_out rising
- div_busy  out  NUM_CH  reload captured, not yet applied
- lock_ok  out  1  qualified lock
- rst_out_n  out  1  fabric reset, equals lock_ok (registered)
- lock_lost_cnt  out  8  saturating count of RUN->WAIT_LOCK transitions

## Operation
- Reset: all outputs 0, FSM in WAIT_LOCK, all active/pending divide values 1, counters 0.
- locked_in passes through a 2-FF synchroniser, giving locked_s.
- Lock FSM:
  - WAIT_LOCK: stab_cnt=0. locked_s=1 -> STABLE_CNT.
  - STABLE_CNT: stab_cnt++. locked_s=0 -> WAIT_LOCK. stab_cnt==LOCK_STABLE-1 -> RUN.
  - RUN: lock_ok=1, rst_out_n=1. locked_s=0 -> WAIT_LOCK, and lock_lost_cnt++ saturating at 255.
- Channel i runs when run_i = ch_en[i] & lock_ok.
- Divider: hp = active value, with 0 treated as 1. cnt counts 0..hp-1. At the edge where cnt==hp-1, clk_div_out toggles and cnt returns to 0. Output frequency is f_clk/(2*hp) at 50% duty.
- clk_div_ce[i] = 1 for exactly the cycle in which clk_div_out[i] is first high.
- Reload:
  - div_load[i] captures div_val into the pending register and sets div_busy.
  - Pending is applied at the next high->low toggle (end of a full period), or on the next edge if the channel is idle with out=0. div_busy clears on that same edge.
  - A new div_load while busy overwrites pending; the last value wins.
- Disable (ch_en falls):
  - out=1: finish the current high half-period, fall, then hold 0.
  - out=0: stop at once, cnt=0.
- Lock loss: all channels force out=0, ce=0, cnt=0 on the edge after lock_ok falls. Pending reloads are kept.
- div_load coincident with a toggle edge: the value is captured as pending and applies at the following high->low toggle, never mid-period.

## Timing
- lock_ok/rst_out_n rise LOCK_STABLE+3 edges after the first edge that samples locked_in=1, provided it stays high.
- lock_ok falls 3 edges after the first edge that samples locked_in=0.
- First clk_div_out rise occurs hp edges after the first edge with run_i=1. Rising edges then recur every 2*hp edges.
- div_busy is set on the edge that samples div_load, and clears on the apply edge.
- No combinational path from inputs to outputs.

## Configuration
- CLK_DIV_LOCK_FILTER_EN defined: STABLE_CNT filtering as above.
- CLK_DIV_LOCK_FILTER_EN undefined: the STABLE_CNT state and stab_cnt are removed. WAIT_LOCK goes directly to RUN when locked_s=1, so lock_ok rises 3 edges after locked_in. LOCK_STABLE and LOCK_CNT_W are ignored. lock_lost_cnt behaviour is unchanged.

## Test plan
- Reset: rst_n=0 mid-run with outputs toggling -> all outputs 0 immediately; lock_lost_cnt=0.
- Lock qualification: LOCK_STABLE=16; locked_in high with a 1-cycle low glitch at cycle 10 -> counting restarts. From a clean high, lock_ok=1 exactly 19 edges later. Without the macro -> 3 edges.
- Divider: ch0 hp=3 enabled -> first rise 3 edges after start, period 6, high 3 cycles, one ce per period. hp=0 -> period 2.
- Reload: hp=4 running; load 2 during the high phase -> current period completes at 8 cycles, then period 4; div_busy high until the apply edge. Two loads in a row -> the last value is applied.
- Lock loss: locked_in low during RUN with out=1 -> out=0 on the edge after lock_ok falls, rst_out_n=0, lock_lost_cnt=1. Repeat 300 times -> lock_lost_cnt=255.
- Disable: ch_en low one cycle into a 5-cycle high phase -> out stays high 4 more cycles, falls, and remains 0; other channels are unaffected.
